// File: rtl/mem_responder.sv
// mem_responder: single-port memory target that clears itself after reset and returns reads after RD_LATENCY cycles.
// Define MEM_RESPONDER_STATS_EN to add the wr_count/rd_count/drop_count statistics outputs.
module mem_responder #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int DEPTH      = 256,
  parameter int RD_LATENCY = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          chip_en,
  input  logic          read_write,
  input  logic [AW-1:0] address,
  input  logic [DW-1:0] data_in,
  output logic          ready,
  output logic [DW-1:0] data_out,
  output logic          data_valid,
  output logic          addr_err,
  output logic          cmd_drop
`ifdef MEM_RESPONDER_STATS_EN
  ,
  output logic [31:0]   wr_count,
  output logic [31:0]   rd_count,
  output logic [15:0]   drop_count
`endif
);
  typedef enum logic {INIT, RUN} state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] clr_q, clr_d;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] pd_q [RD_LATENCY];
  logic [RD_LATENCY-1:0] pv_q;
  logic          aerr_q, drop_q;
  logic          in_range, acc, drop, wr_acc, rd_acc;
  logic [DW-1:0] rd_word;
  assign ready    = state_q == RUN;
  assign in_range = {1'b0, address} < (AW+1)'(DEPTH);
  assign acc      = chip_en && ready && !reset;
  assign drop     = chip_en && !ready && !reset;
  assign wr_acc   = acc && read_write && in_range;
  assign rd_acc   = acc && !read_write;
  assign rd_word  = in_range ? mem[address] : '0;
  always_comb begin
    state_d = (state_q == INIT && clr_q == AW'(DEPTH - 1)) ? RUN : state_q;
    clr_d   = (state_q == INIT) ? clr_q + 1'b1 : clr_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= INIT;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end
  // No command is accepted while INIT sweeps the array, so the two write sources never collide.
  always_ff @(posedge clock) begin
    if (state_q == INIT) mem[clr_q] <= '0;
    else if (wr_acc) mem[address] <= data_in;
  end
  // Each stage carries zero data when empty, so data_out is 0 whenever data_valid is low.
  always_ff @(posedge clock) begin
    if (reset) begin
      pv_q   <= '0;
      aerr_q <= 1'b0;
      drop_q <= 1'b0;
      for (int i = 0; i < RD_LATENCY; i++) pd_q[i] <= '0;
    end else begin
      pv_q[0] <= rd_acc;
      pd_q[0] <= rd_acc ? rd_word : '0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pv_q[i] <= pv_q[i-1];
        pd_q[i] <= pd_q[i-1];
      end
      aerr_q <= acc && !in_range;
      drop_q <= drop;
    end
  end
  assign data_out   = pd_q[RD_LATENCY-1];
  assign data_valid = pv_q[RD_LATENCY-1];
  assign addr_err   = aerr_q;
  assign cmd_drop   = drop_q;
`ifdef MEM_RESPONDER_STATS_EN
  logic [31:0] wr_cnt_q, rd_cnt_q;
  logic [15:0] drop_cnt_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      wr_cnt_q   <= wr_cnt_q + 32'(wr_acc);
      rd_cnt_q   <= rd_cnt_q + 32'(rd_acc);
      drop_cnt_q <= drop_cnt_q + 16'(drop);
    end
  end
  assign wr_count   = wr_cnt_q;
  assign rd_count   = rd_cnt_q;
  assign drop_count = drop_cnt_q;
`else
`endif
endmodule
